// File: rtl/rgb_to_ycbcr_cfg_if.sv
// Video stream bundle for the RGB->YCbCr converter: raw RGB with syncs and mode select in,
// YCbCr with delayed syncs out.
interface rgb_to_ycbcr_cfg_if #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
);
    logic           pre_frame_vsync;
    logic           pre_frame_hsync;
    logic           pre_frame_de;
    logic [R_W-1:0] img_red;
    logic [G_W-1:0] img_green;
    logic [B_W-1:0] img_blue;
    logic [1:0]     cfg_mode;
    logic           post_frame_vsync;
    logic           post_frame_hsync;
    logic           post_frame_de;
    logic [7:0]     img_y;
    logic [7:0]     img_cb;
    logic [7:0]     img_cr;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de,
        output img_red, img_green, img_blue, cfg_mode,
        input  post_frame_vsync, post_frame_hsync, post_frame_de,
        input  img_y, img_cb, img_cr
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de,
        input  img_red, img_green, img_blue, cfg_mode,
        output post_frame_vsync, post_frame_hsync, post_frame_de,
        output img_y, img_cb, img_cr
    );
endinterface

// File: rtl/rgb_to_ycbcr_cfg.sv
// Three-stage RGB->YCbCr converter with frame-synchronous BT.601/BT.709/Y-only selection,
// rounding, saturation and sync signals kept aligned with the pixel data.
module rgb_to_ycbcr_cfg #(
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5,
    parameter bit EN_ROUND = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    rgb_to_ycbcr_cfg_if.slave bus
);
    localparam logic signed [18:0] RND = EN_ROUND ? 19'sd128 : 19'sd0;
    localparam logic signed [18:0] OFS = 19'sd32768;

    // Order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); signs are applied in the adder stage.
    localparam logic [7:0] C601 [9] = '{8'd77, 8'd150, 8'd29, 8'd43, 8'd85, 8'd128, 8'd128, 8'd107, 8'd21};
    localparam logic [7:0] C709 [9] = '{8'd54, 8'd183, 8'd19, 8'd29, 8'd99, 8'd128, 8'd128, 8'd116, 8'd12};

    logic [7:0] r8, g8, b8;

    generate
        if (R_W == 8) begin : g_r_pass
            assign r8 = bus.img_red;
        end else begin : g_r_exp
            assign r8 = {bus.img_red, bus.img_red[R_W-1 -: 8-R_W]};
        end
        if (G_W == 8) begin : g_g_pass
            assign g8 = bus.img_green;
        end else begin : g_g_exp
            assign g8 = {bus.img_green, bus.img_green[G_W-1 -: 8-G_W]};
        end
        if (B_W == 8) begin : g_b_pass
            assign b8 = bus.img_blue;
        end else begin : g_b_exp
            assign b8 = {bus.img_blue, bus.img_blue[B_W-1 -: 8-B_W]};
        end
    endgenerate

    logic [7:0]  pix [3];
    assign pix[0] = r8;
    assign pix[1] = g8;
    assign pix[2] = b8;

    logic        vsync_q_reg;
    logic [1:0]  active_mode_reg;
    logic        use_709;
    logic [15:0] prod [9];
    logic [15:0] prod_reg [9];
    logic [1:0]  tag_s1_reg, tag_s2_reg;
    logic signed [18:0] y_sum_next, cb_sum_next, cr_sum_next;
    logic signed [18:0] y_sum_reg, cb_sum_reg, cr_sum_reg;
    logic [7:0]  y_reg, cb_reg, cr_reg;
    logic [2:0]  sync_sr_reg [3];

    assign use_709 = (active_mode_reg == 2'b01);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign prod[gi] = 16'(pix[gi % 3]) * 16'(use_709 ? C709[gi] : C601[gi]);
        end
    endgenerate

    function automatic logic signed [18:0] ext(input logic [15:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [18:0] s);
        logic signed [18:0] t;
        t = s >>> 8;
        if (t < 0)
            return 8'd0;
        else if (t > 255)
            return 8'd255;
        else
            return t[7:0];
    endfunction

    assign y_sum_next  = ext(prod_reg[0]) + ext(prod_reg[1]) + ext(prod_reg[2]) + RND;
    assign cb_sum_next = OFS + RND - ext(prod_reg[3]) - ext(prod_reg[4]) + ext(prod_reg[5]);
    assign cr_sum_next = OFS + RND + ext(prod_reg[6]) - ext(prod_reg[7]) - ext(prod_reg[8]);

    // A new mode is taken only on the rising vsync edge; the tag keeps in-flight pixels consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_reg     <= 1'b0;
            active_mode_reg <= 2'b00;
            tag_s1_reg      <= 2'b00;
            tag_s2_reg      <= 2'b00;
            y_sum_reg       <= '0;
            cb_sum_reg      <= '0;
            cr_sum_reg      <= '0;
            y_reg           <= 8'd0;
            cb_reg          <= 8'd0;
            cr_reg          <= 8'd0;
            for (int i = 0; i < 9; i++) prod_reg[i] <= 16'd0;
            for (int i = 0; i < 3; i++) sync_sr_reg[i] <= 3'b000;
        end else begin
            vsync_q_reg <= bus.pre_frame_vsync;
            if (bus.pre_frame_vsync && !vsync_q_reg)
                active_mode_reg <= bus.cfg_mode;

            for (int i = 0; i < 9; i++) prod_reg[i] <= prod[i];
            tag_s1_reg <= active_mode_reg;

            y_sum_reg  <= y_sum_next;
            cb_sum_reg <= cb_sum_next;
            cr_sum_reg <= cr_sum_next;
            tag_s2_reg <= tag_s1_reg;

            y_reg <= clamp8(y_sum_reg);
            if (tag_s2_reg == 2'b10) begin
                cb_reg <= 8'd128;
                cr_reg <= 8'd128;
            end else begin
                cb_reg <= clamp8(cb_sum_reg);
                cr_reg <= clamp8(cr_sum_reg);
            end

            sync_sr_reg[0] <= {bus.pre_frame_vsync, bus.pre_frame_hsync, bus.pre_frame_de};
            sync_sr_reg[1] <= sync_sr_reg[0];
            sync_sr_reg[2] <= sync_sr_reg[1];
        end
    end

    assign bus.post_frame_vsync = sync_sr_reg[2][2];
    assign bus.post_frame_hsync = sync_sr_reg[2][1];
    assign bus.post_frame_de    = sync_sr_reg[2][0];
    assign bus.img_y  = sync_sr_reg[2][0] ? y_reg  : 8'd0;
    assign bus.img_cb = sync_sr_reg[2][0] ? cb_reg : 8'd0;
    assign bus.img_cr = sync_sr_reg[2][0] ? cr_reg : 8'd0;
endmodule
